// File: rtl/clock_disp_pkg.sv
// ============================================================================
// clock_disp_pkg: shared constants and helpers for the HH.MM.SS scan display.
// Revision: 1.0
// ============================================================================
`default_nettype none

package clock_disp_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   // Active-high g..a patterns for decimal digits 0-9
   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   typedef enum logic [1:0] {
      FIELD_SEC = 2'd0,
      FIELD_MIN = 2'd1,
      FIELD_HR  = 2'd2
   } field_e;

   typedef struct packed {
      field_e fld;
      logic   tens;
   } digit_map_t;

   // Index pairs walk sec, min, hr; odd indices select the tens digit
   function automatic digit_map_t digit_map(input logic [2:0] idx);
      digit_map_t m;
      case (idx[2:1])
         2'd0:    m.fld = FIELD_SEC;
         2'd1:    m.fld = FIELD_MIN;
         default: m.fld = FIELD_HR;
      endcase
      m.tens = idx[0];
      return m;
   endfunction

   // Returns {tens[2:0], ones[3:0]} for 0..63 using compares, shifts and adds
   function automatic logic [6:0] bin2bcd(input logic [5:0] v);
      logic [2:0] t;
      logic [3:0] o;
      if      (v >= 6'd60) t = 3'd6;
      else if (v >= 6'd50) t = 3'd5;
      else if (v >= 6'd40) t = 3'd4;
      else if (v >= 6'd30) t = 3'd3;
      else if (v >= 6'd20) t = 3'd2;
      else if (v >= 6'd10) t = 3'd1;
      else                 t = 3'd0;
      o = v[3:0] - ({t[0], 3'b000} + {t, 1'b0});
      return {t, o};
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
// seg7_decoder: BCD digit (or dash) to active-high g..a segment pattern.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_decoder
   import clock_disp_pkg::*;
(
   input  logic [3:0] bcd_i,
   input  logic       dash_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_OFF;
      if (dash_i)
         seg_o = SEG_DASH;
      else if (bcd_i <= 4'd9)
         seg_o = SEG_DIGIT[bcd_i];
   end

endmodule

`default_nettype wire

// File: rtl/clock_display_scan.sv
// ============================================================================
// clock_display_scan: six-digit multiplexed HH.MM.SS driver with per-frame snapshot.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clock_display_scan
   import clock_disp_pkg::*;
#(
   parameter int SCAN_DIV   = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [4:0] hr,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_start
);

   localparam int               DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);
   localparam logic             POL      = (ACTIVE_LOW != 0);

   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       idx_q, idx_d;
   logic [5:0]       sec_q, min_q;
   logic [4:0]       hr_q;
   logic             wrap_q;
   logic [5:0]       an_q;
   logic [6:0]       seg_q;
   logic             dp_q;
   logic             frame_start_q;

   logic             tc;
   logic             wrap;
   digit_map_t       dmap;
   logic [5:0]       val;
   logic [6:0]       bcd;
   logic [3:0]       digit;
   logic             oor;
   logic             dp_log;
   logic [5:0]       an_log;
   logic [6:0]       seg_log;

   always_comb begin
      tc    = (div_q == DIV_LAST);
      wrap  = tc && (idx_q == IDX_LAST);
      div_d = tc ? '0 : div_q + DIV_W'(1);
      idx_d = idx_q;
      if (tc)
         idx_d = wrap ? 3'd0 : idx_q + 3'd1;

      dmap = digit_map(idx_q);
      case (dmap.fld)
         FIELD_SEC: val = sec_q;
         FIELD_MIN: val = min_q;
         default:   val = {1'b0, hr_q};
      endcase
      bcd   = bin2bcd(val);
      digit = dmap.tens ? {1'b0, bcd[6:4]} : bcd[3:0];

      // Any field out of range blanks the whole frame to dashes
      oor    = (sec_q > 6'd59) || (min_q > 6'd59) || (hr_q > 5'd23);
      dp_log = !oor && ((idx_q == 3'd2) || (idx_q == 3'd4));
      an_log = 6'd1 << idx_q;
   end

   seg7_decoder u_seg7_decoder (
      .bcd_i  (digit),
      .dash_i (oor),
      .seg_o  (seg_log)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q         <= '0;
         idx_q         <= 3'd0;
         sec_q         <= 6'd0;
         min_q         <= 6'd0;
         hr_q          <= 5'd0;
         wrap_q        <= 1'b0;
         frame_start_q <= 1'b0;
         an_q          <= {6{POL}};
         seg_q         <= SEG_OFF ^ {7{POL}};
         dp_q          <= POL;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
         if (wrap) begin
            sec_q <= sec;
            min_q <= min;
            hr_q  <= hr;
         end
         // Delayed by one so the pulse lines up with digit 0 appearing on an
         wrap_q        <= wrap;
         frame_start_q <= wrap_q;
         an_q          <= an_log ^ {6{POL}};
         seg_q         <= seg_log ^ {7{POL}};
         dp_q          <= dp_log ^ POL;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: doc/clock_display_scan.md
CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot (legal values are 2 or more).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1; when it is 1, an and seg are active-low (0 = lit/enabled).
REQ-003 SHALL have port clk, input, 1 bit, sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port sec, input, 6 bits, binary seconds from the time counter.
REQ-006 SHALL have port min, input, 6 bits, binary minutes.
REQ-007 SHALL have port hr, input, 5 bits, binary hours.
REQ-008 SHALL have port an, output, 6 bits, one-hot digit enable; an[0] = sec ones, an[5] = hr tens.
REQ-009 SHALL have port seg, output, 7 bits, segments, seg[6:0] = g,f,e,d,c,b,a.
REQ-010 SHALL have port dp, output, 1 bit, decimal point acting as the HH.MM.SS separator.
REQ-011 SHALL have port frame_start, output, 1 bit, one-cycle pulse when digit 0 of a new frame is first driven.
REQ-012 SHALL use one clock; reset is synchronous and active-high; the ports are named clk and rst.

Function
REQ-013 SHALL count cycles with a divider (0..SCAN_DIV-1, wrapping); a terminal count (TC) is a divider value of SCAN_DIV-1.
REQ-014 SHALL advance the 3-bit digit index 0->1->...->5->0 on each TC; values 6 and 7 are never reached.
REQ-015 SHALL load the sec/min/hr snapshot registers on the same edge where the index wraps 5->0; at no other time.
REQ-016 SHALL derive all displayed digits from the snapshot only, so input changes mid-frame never tear the display.
REQ-017 SHALL split each value as tens = v/10, ones = v%10 (value range 0..63); no multiplier or divider IP.
REQ-018 SHALL map index to digit as: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hr ones, 5 hr tens.
REQ-019 SHALL flag the snapshot out-of-range if sec>59, min>59 or hr>23; all six digits then show dash (g only) and dp stays off for that whole frame.
REQ-020 SHALL assert dp (logical) on index 2 and 4 only, when the snapshot is in range.
REQ-021 SHALL use the active-high digit patterns 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F, dash:40; ACTIVE_LOW inverts seg, dp and an.
REQ-022 SHALL register an, seg and dp; outputs reflect the index and snapshot held after edge E at edge E+1 (one cycle latency).
REQ-023 SHALL assert frame_start for exactly one cycle, coincident with the first cycle an selects digit 0 after a wrap.
REQ-024 SHALL always drive exactly one an bit enabled outside reset.
REQ-025 SHALL NOT suppress leading zeros; a tens digit of 0 shows "0".

Reset
REQ-026 SHALL, while rst=1 on a clock edge, set divider=0, index=0, snapshot=0 and frame_start=0, with all an and seg disabled/unlit and dp unlit (ACTIVE_LOW polarity applied).
REQ-027 SHALL, on the first edge with rst=0, drive digit 0 of snapshot 0 (pattern 3F) with frame_start=0; the first displayed frame is 00.00.00.
REQ-028 SHALL let rst asserted mid-frame take effect on that edge and override TC and snapshot load.

Structure
REQ-029 SHALL place NUM_DIGITS=6, the segment pattern constants, SEG_DASH, SEG_OFF and the digit-index-to-field mapping in package clock_disp_pkg.
REQ-030 SHALL use one combinational sub-module, seg7_decoder, mapping 4-bit BCD plus a dash flag to 7-bit active-high segments.

Verification (SCAN_DIV=4, ACTIVE_LOW=0 unless stated)
REQ-031 SHALL check: rst released with inputs 12:34:56 -> the first frame shows 000000 with an cycling 01,02,04,08,10,20 every 4 cycles; the second frame shows ones/tens 6,5,4,3,2,1 (seg 7D,6D,66,4F,5B,06) with frame_start pulsed once.
REQ-032 SHALL check: inputs changing every cycle mid-frame -> the displayed digits change only at frame boundaries, matching the inputs sampled at the 5->0 wrap edge.
REQ-033 SHALL check: sec=60 at a wrap -> the whole next frame shows 40 on every digit with dp=0; sec=59 at the following wrap -> normal display resumes.
REQ-034 SHALL check: 23:59:59 -> digits 9,5,9,5,3,2 with dp=1 only while an=04 and an=10.
REQ-035 SHALL check: rst pulsed while index=3 -> the next edge gives an=00 and seg=00; after release, digit 0 shows 3F.
REQ-036 SHALL check: ACTIVE_LOW=1, inputs 00:00:00 -> an is an active-low one-hot, seg=40 for "0", and dp is high except on index 2 and 4.
